// File: rtl/i2c_master_stream.sv
// i2c_master_stream: open-drain I2C master running multi-byte write/read
// transactions with ACK/NACK sampling, clock stretching and a byte-streaming
// host handshake. Every bus phase is four quarters of DIV clks each.
`timescale 1ns/1ps
module i2c_master_stream #(
   parameter int DIV   = 63,
   parameter int LEN_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             rw,
   input  logic [6:0]       dev_addr,
   input  logic [LEN_W-1:0] len,
   input  logic [7:0]       tx_data,
   output logic             tx_next,
   output logic [7:0]       rx_data,
   output logic             rx_valid,
   output logic             busy,
   output logic             done,
   output logic             nack,
   inout  wire              scl,
   inout  wire              sda
);

   typedef enum logic [3:0] {
      S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WDATA, S_WACK, S_RDATA, S_MACK, S_STOP
   } state_t;

   localparam logic [15:0] DIV_M1 = 16'(DIV - 1);

   state_t           state, state_next;
   logic [15:0]      tick_cnt;
   logic [1:0]       quarter;
   logic [2:0]       bit_cnt;
   logic [LEN_W-1:0] byte_cnt;
   logic [LEN_W-1:0] len_reg;
   logic             rw_reg;
   logic [7:0]       shift_reg;
   logic             sda_sample;
   logic             scl_low, sda_low;
   logic             scl_in, sda_in;
   logic             stretch_hold, q_adv, phase_end;

   // Pads are open-drain: only ever pull low, and let go the instant reset asserts.
   assign scl    = (scl_low && rst_n) ? 1'b0 : 1'bz;
   assign sda    = (sda_low && rst_n) ? 1'b0 : 1'bz;
   assign scl_in = scl;
   assign sda_in = sda;

   // A target holding SCL low during q2 freezes the quarter timer at 0.
   assign stretch_hold = (quarter == 2'd2) && !scl_in;
   assign q_adv        = (tick_cnt == DIV_M1) && !stretch_hold;
   assign phase_end    = q_adv && (quarter == 2'd3);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_next;
   end

   // Next-state logic: transitions only at the end of a four-quarter phase.
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:     if (start) state_next = S_START;
         S_START:    if (phase_end) state_next = S_ADDR;
         S_ADDR:     if (phase_end && bit_cnt == 3'd7) state_next = S_ADDR_ACK;
         S_ADDR_ACK: if (phase_end) begin
                        if (sda_sample || len_reg == '0) state_next = S_STOP;
                        else if (rw_reg)                 state_next = S_RDATA;
                        else                             state_next = S_WDATA;
                     end
         S_WDATA:    if (phase_end && bit_cnt == 3'd7) state_next = S_WACK;
         S_WACK:     if (phase_end) begin
                        if (sda_sample || byte_cnt == len_reg) state_next = S_STOP;
                        else                                   state_next = S_WDATA;
                     end
         S_RDATA:    if (phase_end && bit_cnt == 3'd7) state_next = S_MACK;
         S_MACK:     if (phase_end) begin
                        if (byte_cnt == len_reg) state_next = S_STOP;
                        else                     state_next = S_RDATA;
                     end
         S_STOP:     if (phase_end) state_next = S_IDLE;
         default:    state_next = S_IDLE;
      endcase
   end

   // Line drive pattern per state and quarter; bit slots hold SCL low in q0/q1.
   always_comb begin
      scl_low = 1'b0;
      sda_low = 1'b0;
      busy    = (state != S_IDLE);
      case (state)
         S_START: begin
            sda_low = quarter[1];
            scl_low = (quarter == 2'd3);
         end
         S_ADDR, S_WDATA: begin
            scl_low = !quarter[1];
            sda_low = !shift_reg[7];
         end
         S_ADDR_ACK, S_WACK, S_RDATA: scl_low = !quarter[1];
         S_MACK: begin
            scl_low = !quarter[1];
            sda_low = (byte_cnt != len_reg);
         end
         S_STOP: begin
            scl_low = (quarter == 2'd0);
            sda_low = (quarter != 2'd3);
         end
         default: ;
      endcase
   end

   // Quarter timer, bit/byte counters, shift register and host-side pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_cnt   <= '0;
         quarter    <= '0;
         bit_cnt    <= '0;
         byte_cnt   <= '0;
         len_reg    <= '0;
         rw_reg     <= 1'b0;
         shift_reg  <= '0;
         sda_sample <= 1'b1;
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         tx_next    <= 1'b0;
         done       <= 1'b0;
         nack       <= 1'b0;
      end else begin
         tx_next  <= 1'b0;
         rx_valid <= 1'b0;
         done     <= 1'b0;
         if (state == S_IDLE) begin
            tick_cnt <= '0;
            quarter  <= '0;
            if (start) begin
               rw_reg    <= rw;
               len_reg   <= len;
               shift_reg <= {dev_addr, rw};
               nack      <= 1'b0;
               bit_cnt   <= '0;
               byte_cnt  <= '0;
            end
         end else begin
            if (stretch_hold) begin
               tick_cnt <= '0;
            end else if (q_adv) begin
               tick_cnt <= '0;
               quarter  <= quarter + 2'd1;
            end else begin
               tick_cnt <= tick_cnt + 16'd1;
            end
            if (q_adv && quarter == 2'd2) sda_sample <= sda_in;
            if (phase_end) begin
               case (state)
                  S_ADDR, S_WDATA: begin
                     bit_cnt   <= bit_cnt + 3'd1;
                     shift_reg <= {shift_reg[6:0], 1'b0};
                  end
                  S_RDATA: begin
                     bit_cnt   <= bit_cnt + 3'd1;
                     shift_reg <= {shift_reg[6:0], sda_sample};
                     if (bit_cnt == 3'd7) begin
                        rx_data  <= {shift_reg[6:0], sda_sample};
                        rx_valid <= 1'b1;
                     end
                  end
                  S_ADDR_ACK, S_WACK: if (sda_sample) nack <= 1'b1;
                  S_STOP: done <= 1'b1;
                  default: ;
               endcase
               // Entering a write byte: capture the host byte and ask for the next one.
               if (state_next == S_WDATA && state != S_WDATA) begin
                  shift_reg <= tx_data;
                  tx_next   <= 1'b1;
               end
               if ((state_next == S_WDATA || state_next == S_RDATA) && state_next != state)
                  byte_cnt <= (state == S_ADDR_ACK) ? LEN_W'(1) : byte_cnt + LEN_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_i2c_master_stream.sv
// Table-driven bench for i2c_master_stream with a clk-sampled slave/bus model.
`timescale 1ns/1ps
module tb_i2c_master_stream;
   localparam int DIV = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       rw = 1'b0;
   logic [6:0] dev_addr = 7'h00;
   logic [3:0] len = 4'd0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_next, rx_valid, busy, done, nack;
   logic [7:0] rx_data;
   wire        scl, sda;

   logic scl_slv_low = 1'b0;
   logic sda_slv_low = 1'b0;
   pullup (scl);
   pullup (sda);
   assign scl = scl_slv_low ? 1'b0 : 1'bz;
   assign sda = sda_slv_low ? 1'b0 : 1'bz;

   i2c_master_stream #(.DIV(DIV), .LEN_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .rw(rw), .dev_addr(dev_addr),
      .len(len), .tx_data(tx_data), .tx_next(tx_next), .rx_data(rx_data),
      .rx_valid(rx_valid), .busy(busy), .done(done), .nack(nack),
      .scl(scl), .sda(sda)
   );

   always #5 clk = ~clk;

   // slave configuration, written only by the stimulus process
   bit              slave_present = 1'b1;
   int              nack_byte = 0;
   bit              stretch_en = 1'b0;
   logic [2:0][7:0] rd_bytes = '0;

   // slave/bus-decoder state, written only by the model process
   bit              p_scl = 1'b1, p_sda = 1'b1;
   bit              active = 1'b0, is_read = 1'b0, last_ack_low = 1'b0;
   int              bit_idx = 0, byte_idx = 0, n_bytes = 0, n_acks = 0;
   int              stretch_cnt = 0, high_run = 0, min_high = 1000;
   logic [7:0]      shift_in = 8'h00;
   logic [7:0]      cur_byte;
   logic [7:0][7:0] bus_bytes = '0;
   logic [7:0]      bus_acks = '0;

   // Bus model: decodes START/STOP/bits and plays an ACKing, stretching target.
   always @(negedge clk) begin
      bit c_scl, c_sda;
      c_scl = (scl !== 1'b0);
      c_sda = (sda !== 1'b0);
      if (stretch_cnt > 0) begin
         stretch_cnt = stretch_cnt - 1;
         if (stretch_cnt == 0) scl_slv_low = 1'b0;
      end
      if (p_scl && c_scl && p_sda && !c_sda) begin
         active = 1'b1; bit_idx = 0; byte_idx = 0; is_read = 1'b0;
         n_bytes = 0; n_acks = 0; min_high = 1000; sda_slv_low = 1'b0;
      end else if (p_scl && c_scl && !p_sda && c_sda) begin
         active = 1'b0; sda_slv_low = 1'b0;
      end else if (active && !p_scl && c_scl) begin
         if (bit_idx < 8) begin
            shift_in = {shift_in[6:0], c_sda};
         end else if (bit_idx == 8) begin
            if (n_acks < 8) bus_acks[n_acks] = c_sda;
            n_acks = n_acks + 1;
            last_ack_low = !c_sda;
         end
         bit_idx = bit_idx + 1;
         if (bit_idx == 8) begin
            if (n_bytes < 8) bus_bytes[n_bytes] = shift_in;
            n_bytes = n_bytes + 1;
            if (byte_idx == 0) is_read = shift_in[0];
         end
      end else if (active && p_scl && !c_scl) begin
         if (high_run < min_high) min_high = high_run;
         if (bit_idx == 8) begin
            if (byte_idx == 0)  sda_slv_low = slave_present;
            else if (!is_read)  sda_slv_low = slave_present && (byte_idx != nack_byte);
            else                sda_slv_low = 1'b0;
            if (stretch_en && byte_idx == 1) begin
               scl_slv_low = 1'b1;
               stretch_cnt = 2 * DIV + 50;
            end
         end else if (bit_idx == 9) begin
            bit_idx = 0;
            byte_idx = byte_idx + 1;
            if (is_read && last_ack_low && byte_idx <= 3) begin
               cur_byte = rd_bytes[byte_idx-1];
               sda_slv_low = !cur_byte[7];
            end else begin
               sda_slv_low = 1'b0;
            end
         end else if (is_read && byte_idx > 0 && byte_idx <= 3 && bit_idx < 8) begin
            cur_byte = rd_bytes[byte_idx-1];
            sda_slv_low = !cur_byte[7-bit_idx];
         end else begin
            sda_slv_low = 1'b0;
         end
      end
      high_run = c_scl ? high_run + 1 : 0;
      p_scl = c_scl;
      p_sda = c_sda;
   end

   typedef struct {
      bit              rw;
      logic [6:0]      addr;
      logic [3:0]      len;
      logic [7:0]      b0, b1, b2;
      bit              slave;
      int              nack_byte;
      bit              collide;
      bit              stretch;
      int              exp_dur;
      bit              exp_nack;
      int              exp_txn;
      int              exp_rxn;
      int              exp_nbytes;
      logic [3:0][7:0] exp_bytes;
      logic [3:0]      exp_acks;
   } vec_t;

   vec_t vecs[7];

   int n_checks = 0;
   int n_fail = 0;

   int              r_dur, r_txn, r_rxn, r_done_cnt;
   logic [3:0][7:0] r_rx;
   logic            r_nack, r_nack_clr, r_busy_rise, r_timeout, r_busy_at_done, r_busy_after;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic run_txn(input vec_t v);
      int              tx_idx;
      int              cyc;
      logic [3:0][7:0] txb;
      txb = {8'h00, v.b2, v.b1, v.b0};
      rw = v.rw; dev_addr = v.addr; len = v.len; tx_data = v.b0; tx_idx = 0;
      slave_present = v.slave; nack_byte = v.nack_byte; stretch_en = v.stretch;
      rd_bytes = {v.b2, v.b1, v.b0};
      r_dur = 0; r_txn = 0; r_rxn = 0; r_rx = '0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      r_nack_clr  = nack;
      r_busy_rise = busy;
      cyc = 0;
      while (!done && cyc < 3000) begin
         if (busy) r_dur = r_dur + 1;
         if (tx_next) begin
            r_txn = r_txn + 1;
            if (tx_idx < 3) tx_idx = tx_idx + 1;
            tx_data = txb[tx_idx];
         end
         if (rx_valid) begin
            if (r_rxn < 4) r_rx[r_rxn] = rx_data;
            r_rxn = r_rxn + 1;
         end
         if (v.collide && cyc == 100) begin
            start = 1'b1; dev_addr = 7'h11; len = 4'd0; rw = ~v.rw;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         cyc = cyc + 1;
      end
      r_timeout      = !done;
      r_busy_at_done = busy;
      r_nack         = nack;
      r_done_cnt     = 0;
      for (int i = 0; i < 4; i++) begin
         if (done) r_done_cnt = r_done_cnt + 1;
         @(negedge clk);
      end
      r_busy_after = busy;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //            rw  addr   len  b0     b1     b2    slv nb col str dur nack txn rxn nby bytes                          acks
      vecs[0] = '{1'b0, 7'h50, 4'd2, 8'hA5, 8'h3C, 8'h00, 1'b1, 0, 1'b0, 1'b0, 464, 1'b0, 2, 0, 3, {8'h00, 8'h3C, 8'hA5, 8'hA0}, 4'b0000};
      vecs[1] = '{1'b1, 7'h68, 4'd3, 8'h12, 8'h34, 8'h56, 1'b1, 0, 1'b0, 1'b0, 608, 1'b0, 0, 3, 4, {8'h56, 8'h34, 8'h12, 8'hD1}, 4'b1000};
      vecs[2] = '{1'b0, 7'h2A, 4'd0, 8'h00, 8'h00, 8'h00, 1'b0, 0, 1'b0, 1'b0, 176, 1'b1, 0, 0, 1, {8'h00, 8'h00, 8'h00, 8'h54}, 4'b0001};
      vecs[3] = '{1'b0, 7'h2A, 4'd0, 8'h00, 8'h00, 8'h00, 1'b1, 0, 1'b0, 1'b0, 176, 1'b0, 0, 0, 1, {8'h00, 8'h00, 8'h00, 8'h54}, 4'b0000};
      vecs[4] = '{1'b0, 7'h3B, 4'd3, 8'h11, 8'h22, 8'h33, 1'b1, 2, 1'b0, 1'b0, 464, 1'b1, 2, 0, 3, {8'h00, 8'h22, 8'h11, 8'h76}, 4'b0100};
      vecs[5] = '{1'b0, 7'h50, 4'd1, 8'h5A, 8'h00, 8'h00, 1'b1, 0, 1'b1, 1'b0, 320, 1'b0, 1, 0, 2, {8'h00, 8'h00, 8'h5A, 8'hA0}, 4'b0000};
      vecs[6] = '{1'b0, 7'h50, 4'd1, 8'h77, 8'h00, 8'h00, 1'b1, 0, 1'b0, 1'b1, 370, 1'b0, 1, 0, 2, {8'h00, 8'h00, 8'h77, 8'hA0}, 4'b0000};

      // reset values
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_nack", nack, 0);
      check("rst_tx_next", tx_next, 0);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_rx_data", rx_data, 8'h00);
      check("rst_scl", scl, 1);
      check("rst_sda", sda, 1);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_busy", busy, 0);

      for (int k = 0; k < 7; k++) begin
         run_txn(vecs[k]);
         $display("txn %0d: rw=%0d addr=%h len=%0d dur=%0d tx_next=%0d rx=%0d nack=%0d bus_bytes=%0d",
                  k, vecs[k].rw, vecs[k].addr, vecs[k].len, r_dur, r_txn, r_rxn, r_nack, n_bytes);
         check($sformatf("v%0d_busy_rise", k), r_busy_rise, 1);
         check($sformatf("v%0d_nack_clr", k), r_nack_clr, 0);
         check($sformatf("v%0d_done_seen", k), !r_timeout, 1);
         check($sformatf("v%0d_busy_at_done", k), r_busy_at_done, 0);
         check($sformatf("v%0d_done_once", k), r_done_cnt, 1);
         check($sformatf("v%0d_busy_after", k), r_busy_after, 0);
         check($sformatf("v%0d_duration", k), r_dur, vecs[k].exp_dur);
         check($sformatf("v%0d_nack", k), r_nack, vecs[k].exp_nack);
         check($sformatf("v%0d_tx_next_cnt", k), r_txn, vecs[k].exp_txn);
         check($sformatf("v%0d_rx_cnt", k), r_rxn, vecs[k].exp_rxn);
         check($sformatf("v%0d_bus_nbytes", k), n_bytes, vecs[k].exp_nbytes);
         for (int i = 0; i < vecs[k].exp_rxn; i++)
            check($sformatf("v%0d_rx%0d", k, i), r_rx[i], rd_bytes[i]);
         for (int i = 0; i < vecs[k].exp_nbytes; i++) begin
            check($sformatf("v%0d_byte%0d", k, i), bus_bytes[i], vecs[k].exp_bytes[i]);
            check($sformatf("v%0d_ack%0d", k, i), bus_acks[i], vecs[k].exp_acks[i]);
         end
         if (vecs[k].stretch)
            check($sformatf("v%0d_min_scl_high_ge_div", k), (min_high >= DIV), 1);
      end

      // reset in the middle of the address byte, while both lines are pulled low
      rw = 1'b0; dev_addr = 7'h50; len = 4'd1; tx_data = 8'hC3;
      slave_present = 1'b1; nack_byte = 0; stretch_en = 1'b0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (70) @(negedge clk);
      check("midrst_pre_busy", busy, 1);
      check("midrst_pre_scl", scl, 0);
      check("midrst_pre_sda", sda, 0);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_scl_released", scl, 1);
      check("midrst_sda_released", sda, 1);
      check("midrst_busy", busy, 0);
      begin
         int dcnt;
         dcnt = 0;
         for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) dcnt = dcnt + 1;
         end
         check("midrst_no_done", dcnt, 0);
      end
      $display("txn reset: mid-byte reset applied, busy=%0d scl=%b sda=%b", busy, scl, sda);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
